// File: rtl/peri_mic_capture_if.sv
// Wishbone-style 8-bit peripheral bus bundle for peri_mic_capture.
// Signal names keep the device-side direction suffixes so both ends read naturally.
interface peri_mic_capture_if;
  logic       wb_we_i;
  logic       wb_stb_i;
  logic       wb_ack_o;
  logic [3:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;

  modport master (
    output wb_we_i, wb_stb_i, wb_adr_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_we_i, wb_stb_i, wb_adr_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/peri_mic_capture.sv
// PDM microphone capture: programmable mic clock, ones-count decimation,
// warm-up discard, sample FIFO and level interrupt behind an 8-bit Wishbone port.
module peri_mic_capture #(
  parameter int FifoDepth     = 8,
  parameter int WarmupSamples = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  peri_mic_capture_if.slave wb,
  output logic              mic_clk_o,
  input  logic              mic_data_i,
  output logic              irq_o
);
  localparam int AW = $clog2(FifoDepth);
  localparam logic [7:0]  WarmLast = 8'(WarmupSamples - 1);
  localparam logic [AW:0] FullLvl  = (AW+1)'(FifoDepth);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_e;

  state_e        state_q, state_d;
  logic          ack_q, irq_q, en_q, irqen_q, ovf_q, mic_q;
  logic [7:0]    dat_q, div_q, decim_q, thresh_q;
  logic [7:0]    cnt_q, bits_q, decim_lat_q, warm_q;
  logic [8:0]    acc_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   level_q;
  logic [7:0]    mem_q [FifoDepth];

  logic       access, wr_en, rd_en, en_d, clr, empty, full, pop;
  logic       running, tick, rise, done, push_req, push_ok, ovf_set;
  logic [7:0] limit, sample, rdata;
  logic [8:0] sum;

  assign access = wb.wb_stb_i & ~ack_q;
  assign wr_en  = access & wb.wb_we_i;
  assign rd_en  = access & ~wb.wb_we_i;
  // EN acts on the same edge that acknowledges the CTRL write
  assign en_d   = (wr_en && wb.wb_adr_i == 4'h0) ? wb.wb_dat_i[0] : en_q;
  assign clr    = wr_en && wb.wb_adr_i == 4'h0 && wb.wb_dat_i[1];
  assign empty  = (level_q == '0);
  assign full   = (level_q == FullLvl);
  assign pop    = rd_en && wb.wb_adr_i == 4'h4 && !empty;

  assign running  = (state_q != IDLE) && en_d;
  assign tick     = running && (cnt_q == 8'd0);
  assign rise     = tick && !mic_q;
  assign limit    = (bits_q == 8'd0) ? decim_q : decim_lat_q;
  assign done     = rise && (bits_q == limit);
  assign sum      = acc_q + {8'd0, mic_data_i};
  assign sample   = sum[8] ? 8'hFF : sum[7:0];
  assign push_req = done && (state_q == RUN);
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop && !clr;

  always_comb begin
    state_d = state_q;
    if (!en_d) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = (WarmupSamples == 0) ? RUN : WARMUP;
        WARMUP:  if (done && warm_q == WarmLast) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (wb.wb_adr_i)
      4'h0:    rdata = {5'd0, irqen_q, 1'b0, en_q};
      4'h1:    rdata = div_q;
      4'h2:    rdata = decim_q;
      4'h3:    rdata = {5'd0, ovf_q, full, empty};
      4'h4:    rdata = empty ? 8'h00 : mem_q[rd_q];
      4'h5:    rdata = 8'(level_q);
      4'h6:    rdata = thresh_q;
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      dat_q    <= 8'h00;
      en_q     <= 1'b0;
      irqen_q  <= 1'b0;
      ovf_q    <= 1'b0;
      div_q    <= 8'h01;
      decim_q  <= 8'h3F;
      thresh_q <= 8'h01;
      irq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= wb.wb_stb_i & ~ack_q;
      dat_q   <= rd_en ? rdata : 8'h00;
      en_q    <= en_d;
      if (wr_en) begin
        case (wb.wb_adr_i)
          4'h0:    irqen_q  <= wb.wb_dat_i[2];
          4'h1:    div_q    <= wb.wb_dat_i;
          4'h2:    decim_q  <= wb.wb_dat_i;
          4'h6:    thresh_q <= wb.wb_dat_i;
          default: ;
        endcase
      end
      // a new overflow in the same cycle as a write-1 clear stays set
      if (ovf_set) ovf_q <= 1'b1;
      else if (wr_en && wb.wb_adr_i == 4'h3 && wb.wb_dat_i[2]) ovf_q <= 1'b0;
      irq_q <= irqen_q && (8'(level_q) >= thresh_q) && (thresh_q != 8'h00);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mic_q       <= 1'b0;
      cnt_q       <= 8'h00;
      acc_q       <= 9'd0;
      bits_q      <= 8'd0;
      decim_lat_q <= 8'd0;
      warm_q      <= 8'd0;
    end else if (!running) begin
      mic_q  <= 1'b0;
      cnt_q  <= div_q;
      acc_q  <= 9'd0;
      bits_q <= 8'd0;
      warm_q <= 8'd0;
    end else begin
      if (tick) begin
        cnt_q <= div_q;
        mic_q <= ~mic_q;
      end else begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (rise) begin
        if (bits_q == 8'd0) decim_lat_q <= decim_q;
        if (done) begin
          acc_q  <= 9'd0;
          bits_q <= 8'd0;
        end else begin
          acc_q  <= sum;
          bits_q <= bits_q + 8'd1;
        end
      end
      if (done && state_q == WARMUP) warm_q <= warm_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else if (clr) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop)     rd_q <= rd_q + AW'(1);
      level_q <= level_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= sample;
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign mic_clk_o   = mic_q;
  assign irq_o       = irq_q;
endmodule

// File: tb/tb_peri_mic_capture.sv
// Randomized bench for peri_mic_capture with a cycle-indexed behavioural model
// (mic edges predicted arithmetically from the enable cycle, FIFO as a queue).
module tb_peri_mic_capture;
  localparam int DEPTH = 8;
  localparam int WARM  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mic_data = 1'b0;
  logic mic_clk, irq;

  peri_mic_capture_if bus ();

  peri_mic_capture #(.FifoDepth(DEPTH), .WarmupSamples(WARM)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wb         (bus),
    .mic_clk_o  (mic_clk),
    .mic_data_i (mic_data),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mode = 0;

  // model state
  bit         m_en, m_irqen, m_ovf, irq_exp, mon_on;
  int         m_div, m_decim, m_thresh, t_en, e_cnt, nb, acc, warm, next_done;
  logic [7:0] q[$];
  int         mic_err = 0;
  int         irq_err = 0;
  bit         pw, pr;
  logic [3:0] pw_adr, pr_adr;
  logic [7:0] pw_dat;
  logic [31:0] exp_rd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_irqen = 0; m_ovf = 0; irq_exp = 0;
    m_div = 1; m_decim = 63; m_thresh = 1;
    t_en = 0; e_cnt = 0; nb = 0; acc = 0; warm = 0; next_done = -1;
    q.delete();
    pw = 0; pr = 0;
  endtask

  // Runs between edge n and n+1: checks outputs after edge n, then applies edge n+1.
  task automatic model_step();
    int  n, c, d1, s;
    bit  exp_mic, pop, clr;
    n = cyc; c = cyc + 1; d1 = m_div + 1;
    exp_mic = (m_en && n >= t_en) ? (((n - t_en) / d1) % 2 == 1) : 1'b0;
    if (mic_clk !== exp_mic) mic_err++;
    if (irq !== irq_exp) irq_err++;
    irq_exp = m_irqen && (q.size() >= m_thresh) && (m_thresh != 0);
    pop = 0; clr = 0;
    if (pr) begin
      pr = 0;
      case (pr_adr)
        4'h0: exp_rd = (m_irqen ? 4 : 0) + (m_en ? 1 : 0);
        4'h1: exp_rd = m_div;
        4'h2: exp_rd = m_decim;
        4'h3: exp_rd = (m_ovf ? 4 : 0) + (q.size() == DEPTH ? 2 : 0) + (q.size() == 0 ? 1 : 0);
        4'h4: begin exp_rd = (q.size() != 0) ? 32'(q[0]) : 0; pop = (q.size() != 0); end
        4'h5: exp_rd = q.size();
        4'h6: exp_rd = m_thresh;
        default: exp_rd = 0;
      endcase
    end
    if (pw) begin
      pw = 0;
      case (pw_adr)
        4'h0: begin
          if (pw_dat[0] && !m_en) begin
            t_en = c; e_cnt = 0; nb = 0; acc = 0; warm = 0;
          end
          m_en = pw_dat[0]; m_irqen = pw_dat[2]; clr = pw_dat[1];
        end
        4'h1: m_div = pw_dat;
        4'h2: m_decim = pw_dat;
        4'h3: if (pw_dat[2]) m_ovf = 0;
        4'h6: m_thresh = pw_dat;
        default: ;
      endcase
    end
    if (pop) void'(q.pop_front());
    d1 = m_div + 1;
    if (m_en && c > t_en && (c - t_en) % d1 == 0 && ((c - t_en) / d1) % 2 == 1) begin
      e_cnt++; nb++; acc += int'(mic_data);
      if (nb == m_decim + 1) begin
        s = (acc > 255) ? 255 : acc;
        acc = 0; nb = 0;
        if (warm < WARM) warm++;
        else if (q.size() < DEPTH) q.push_back(8'(s));
        else if (!clr) m_ovf = 1;
      end
    end
    if (clr) q.delete();
    next_done = m_en ? t_en + d1 * (2 * (e_cnt + (m_decim + 1 - nb) - 1) + 1) : -1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mon_on) model_step();

  always @(posedge clk) begin
    #1;
    case (mode)
      1:       mic_data = (e_cnt % 2 == 0);
      2:       mic_data = 1'b1;
      default: mic_data = 1'($urandom % 2);
    endcase
  end

  task automatic wb_write(input logic [3:0] adr, input logic [7:0] dat);
    @(posedge clk); #1;
    bus.wb_stb_i = 1; bus.wb_we_i = 1; bus.wb_adr_i = adr; bus.wb_dat_i = dat;
    pw_adr = adr; pw_dat = dat; pw = 1;
    @(posedge clk); @(negedge clk);
    check_val("wr_ack", 32'(bus.wb_ack_o), 1);
    $display("[TB] wr adr=%0h dat=%02h", adr, dat);
    bus.wb_stb_i = 0; bus.wb_we_i = 0;
  endtask

  task automatic wb_read(input logic [3:0] adr, input string tag, output logic [7:0] val);
    @(posedge clk); #1;
    bus.wb_stb_i = 1; bus.wb_we_i = 0; bus.wb_adr_i = adr;
    pr_adr = adr; pr = 1;
    @(posedge clk); @(negedge clk);
    check_val({tag, "_ack"}, 32'(bus.wb_ack_o), 1);
    check_val(tag, 32'(bus.wb_dat_o), exp_rd);
    val = bus.wb_dat_o;
    $display("[TB] rd %s adr=%0h dat=%02h", tag, adr, val);
    bus.wb_stb_i = 0;
  endtask

  task automatic wait_level(input int lvl, input int budget);
    int i = 0;
    while (q.size() < lvl && i < budget) begin @(posedge clk); i++; end
    if (q.size() < lvl) check_val("timeout_level", q.size(), lvl);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int i;
    bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_adr_i = 0; bus.wb_dat_i = 0;
    model_reset();
    mon_on = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    check_val("rst_mic", 32'(mic_clk), 0);
    check_val("rst_irq", 32'(irq), 0);
    for (int a = 0; a < 7; a++) wb_read(4'(a), $sformatf("rst_reg%0d", a), v);

    // DIV=2 timing, DECIM=7 with alternating data
    mode = 1;
    wb_write(4'h1, 8'd2);
    wb_write(4'h2, 8'd7);
    wb_write(4'h0, 8'h01);
    @(negedge clk); check_val("rise_c1", 32'(mic_clk), 0);
    @(negedge clk); check_val("rise_c2", 32'(mic_clk), 0);
    @(negedge clk); check_val("rise_c3", 32'(mic_clk), 1);
    wait_level(3, 2000);
    wb_read(4'h5, "alt_level", v);
    for (int k = 0; k < 3; k++) begin
      wb_read(4'h4, "alt_data", v);
      check_val("alt_lit", 32'(v), 32'h04);
    end

    // fill, overflow, then a pop coinciding with a push
    wait_level(DEPTH, 3000);
    wb_read(4'h3, "full_status", v);
    i = 0;
    while (!m_ovf && i < 500) begin @(posedge clk); i++; end
    check_val("ovf_seen", 32'(m_ovf), 1);
    wb_read(4'h3, "ovf_status", v);
    wb_write(4'h3, 8'h04);
    i = 0;
    do begin @(posedge clk); #1; i++; end while (next_done != cyc + 2 && i < 500);
    if (next_done != cyc + 2) check_val("timeout_sync", next_done, cyc + 2);
    wb_read(4'h4, "sync_pop", v);
    wb_read(4'h5, "sync_level", v);
    check_val("sync_level_lit", 32'(v), DEPTH);
    wb_read(4'h3, "sync_status", v);
    check_val("sync_ovf_lit", 32'(v[2]), 0);

    // saturation with DECIM=0xFF and constant ones
    wb_write(4'h0, 8'h02);
    mode = 2;
    wb_write(4'h1, 8'd0);
    wb_write(4'h2, 8'hFF);
    wb_write(4'h0, 8'h01);
    wait_level(2, 4000);
    for (int k = 0; k < 2; k++) begin
      wb_read(4'h4, "sat_data", v);
      check_val("sat_lit", 32'(v), 32'hFF);
    end

    // threshold interrupt
    wb_write(4'h0, 8'h02);
    mode = 0;
    wb_write(4'h1, 8'd3);
    wb_write(4'h2, 8'd15);
    wb_write(4'h6, 8'd3);
    wb_write(4'h0, 8'h05);
    wait_level(3, 2000);
    @(negedge clk); check_val("irq_pre", 32'(irq), 0);
    @(negedge clk); check_val("irq_rise", 32'(irq), 1);
    wb_read(4'h4, "irq_pop", v);
    @(negedge clk); check_val("irq_fall", 32'(irq), 0);
    wait_level(3, 2000);
    repeat (2) @(negedge clk);
    wb_write(4'h0, 8'h07);
    @(negedge clk); check_val("irq_clr", 32'(irq), 0);
    wb_read(4'h5, "clr_level", v);
    repeat (37) @(posedge clk);
    wb_write(4'h0, 8'h04);
    check_val("dis_mic", 32'(mic_clk), 0);
    repeat (400) @(posedge clk);
    wb_read(4'h5, "dis_level", v);
    check_val("dis_level_lit", 32'(v), 0);

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      wb_write(4'h0, 8'h02);
      wb_write(4'h1, 8'($urandom_range(0, 3)));
      wb_write(4'h2, 8'($urandom_range(0, 15)));
      wb_write(4'h6, 8'($urandom_range(0, 8)));
      wb_write(4'h0, 8'($urandom_range(0, 1) * 4 + 1));
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 40)) @(posedge clk);
        case ($urandom_range(0, 5))
          0:       wb_write(4'h3, 8'h04);
          1:       wb_write(4'h6, 8'($urandom_range(0, 8)));
          2:       wb_write(4'($urandom_range(7, 15)), 8'($urandom));
          3, 4:    wb_read(4'h4, "rnd_data", v);
          default: wb_read(4'($urandom % 16), "rnd_reg", v);
        endcase
      end
    end

    // asynchronous reset mid-run
    wb_write(4'h0, 8'h02);
    wb_write(4'h1, 8'd0);
    wb_write(4'h2, 8'd1);
    wb_write(4'h6, 8'd1);
    wb_write(4'h0, 8'h05);
    wait_level(1, 2000);
    i = 0;
    do begin @(negedge clk); i++; end while (!(mic_clk && irq) && i < 20);
    check_val("pre_rst_mic", 32'(mic_clk), 1);
    mon_on = 0;
    #1 rst_n = 0;
    #1;
    check_val("arst_mic", 32'(mic_clk), 0);
    check_val("arst_irq", 32'(irq), 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1;
    mon_on = 1;
    wb_read(4'h0, "arst_ctrl", v);
    wb_read(4'h3, "arst_status", v);
    wb_read(4'h5, "arst_level", v);
    wb_read(4'h2, "arst_decim", v);

    check_val("mic_clk_track", mic_err, 0);
    check_val("irq_track", irq_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
